// File: rtl/rf_wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the arbiter state encoding and the {rd, wd} writeback request record.
package rf_wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [0:0] {
        ARB_LSU   = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_req_t;

    localparam int WB_REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/rf_wb_arb_if.sv
// Bus bundle between the execution units and the writeback arbiter.
// The master side drives requests and queries; the slave side is the arbiter.
interface rf_wb_arb_if;
    import rf_wb_arb_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_wd;
    logic                  alu_ready;

    logic                  lsu_valid;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_wd;
    logic                  lsu_ready;

    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_rd;

    logic [REG_ADDR_W-1:0] q_rs1;
    logic [REG_ADDR_W-1:0] q_rs2;
    logic                  busy1;
    logic                  busy2;

    logic                  RFWr;
    logic [REG_ADDR_W-1:0] A3;
    logic [XLEN-1:0]       WD;
    logic                  sb_conflict;

    modport master (
        output alu_valid, alu_rd, alu_wd,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_wd,
        input  lsu_ready,
        output ld_issue, ld_rd,
        output q_rs1, q_rs2,
        input  busy1, busy2,
        input  RFWr, A3, WD, sb_conflict
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_wd,
        output lsu_ready,
        input  ld_issue, ld_rd,
        input  q_rs1, q_rs2,
        output busy1, busy2,
        output RFWr, A3, WD, sb_conflict
    );

endinterface

// File: rtl/wb_fifo.sv
// Small circular FIFO with valid/ready on both sides and an occupancy count.
// Storage is not reset; only pointers and count return to empty.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_ready & out_valid;
    // A full FIFO still takes a new entry when the head leaves on the same edge.
    assign push      = in_valid & (in_ready | pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: LSU returns win by default, buffered ALU results
// are forced through after STARVE_LIM consecutive LSU wins; tracks pending loads.
module rf_wb_arb
    import rf_wb_arb_pkg::*;
#(
    parameter int STARVE_LIM  = 4,
    parameter int AFIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    rf_wb_arb_if.slave bus
);

    localparam int CNT_W  = $clog2(STARVE_LIM + 1);
    localparam int FCNT_W = $clog2(AFIFO_DEPTH + 1);

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [CNT_W-1:0]      starve_q;
    logic [CNT_W-1:0]      starve_d;
    logic [CNT_W-1:0]      starve_inc;

    wb_req_t               alu_req;
    wb_req_t               head;
    logic                  head_valid;
    logic                  fifo_in_ready;
    logic                  fifo_push;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;

    logic                  lsu_ready_c;
    logic                  lsu_grant;
    logic                  alu_grant;

    logic                  rfwr_q;
    logic [REG_ADDR_W-1:0] a3_q;
    logic [XLEN-1:0]       wd_q;

    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic                  conflict_d;
    logic                  conflict_q;

    assign alu_req.rd    = bus.alu_rd;
    assign alu_req.wd    = bus.alu_wd;
    assign bus.alu_ready = rst & fifo_in_ready;
    assign fifo_push     = bus.alu_valid & bus.alu_ready;
    assign fifo_empty    = (fifo_count == '0);

    wb_fifo #(
        .DEPTH (AFIFO_DEPTH),
        .WIDTH (WB_REQ_W)
    ) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fifo_push),
        .in_data   (alu_req),
        .in_ready  (fifo_in_ready),
        .out_valid (head_valid),
        .out_data  (head),
        .out_ready (alu_grant),
        .count     (fifo_count)
    );

    assign starve_inc = starve_q + CNT_W'(1);

    // Grant selection and starvation tracking; nothing is granted while in reset.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        lsu_ready_c = 1'b0;
        lsu_grant   = 1'b0;
        alu_grant   = 1'b0;
        if (rst) begin
            case (state_q)
                ARB_LSU: begin
                    lsu_ready_c = 1'b1;
                    if (bus.lsu_valid) begin
                        lsu_grant = 1'b1;
                    end else if (head_valid) begin
                        alu_grant = 1'b1;
                    end
                end
                ARB_FORCE: begin
                    alu_grant = head_valid;
                    state_d   = ARB_LSU;
                end
                default: state_d = ARB_LSU;
            endcase

            if (alu_grant || fifo_empty) begin
                starve_d = '0;
            end else if (lsu_grant) begin
                if (starve_inc == CNT_W'(STARVE_LIM)) begin
                    state_d  = ARB_FORCE;
                    starve_d = '0;
                end else begin
                    starve_d = starve_inc;
                end
            end
        end
    end

    assign bus.lsu_ready = lsu_ready_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ARB_LSU;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // A grant to x0 is consumed like any other but never reaches the register file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rfwr_q <= 1'b0;
            a3_q   <= '0;
            wd_q   <= '0;
        end else if (lsu_grant && (bus.lsu_rd != '0)) begin
            rfwr_q <= 1'b1;
            a3_q   <= bus.lsu_rd;
            wd_q   <= bus.lsu_wd;
        end else if (alu_grant && (head.rd != '0)) begin
            rfwr_q <= 1'b1;
            a3_q   <= head.rd;
            wd_q   <= head.wd;
        end else begin
            rfwr_q <= 1'b0;
        end
    end

    assign bus.RFWr = rfwr_q;
    assign bus.A3   = a3_q;
    assign bus.WD   = wd_q;

    // Set is applied after clear so a new load to a returning register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (lsu_grant) begin
            pending_d[bus.lsu_rd] = 1'b0;
        end
        if (bus.ld_issue) begin
            pending_d[bus.ld_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        conflict_d = bus.ld_issue && (bus.ld_rd != '0) && pending_q[bus.ld_rd]
                     && !(lsu_grant && (bus.lsu_rd == bus.ld_rd));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.busy1       = pending_q[bus.q_rs1];
    assign bus.busy2       = pending_q[bus.q_rs2];
    assign bus.sb_conflict = conflict_q;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Randomised scoreboard bench for rf_wb_arb: a queue-based reference model predicts
// each register-file write with its edge number; a negedge monitor pops and compares.
module tb_rf_wb_arb;
    import rf_wb_arb_pkg::*;

    localparam int LIM   = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic        rst_n;
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_wd;
        logic        lsu_valid;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_wd;
        logic        ld_issue;
        logic [4:0]  ld_rd;
        logic [4:0]  q_rs1;
        logic [4:0]  q_rs2;
    } stim_t;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    rf_wb_arb_if bus();

    rf_wb_arb #(
        .STARVE_LIM  (LIM),
        .AFIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    logic rst_seen = 1'b0;

    // Reference model state: ALU buffer contents, force flag, starvation run, pending set.
    wb_req_t     mq[$];
    exp_t        expq[$];
    bit          mforce;
    int          mstarve;
    bit [31:0]   mpend;
    bit          exp_sbc;
    bit          sbc_known   = 1'b0;
    bit          model_valid = 1'b0;
    logic [4:0]  last_a3;
    logic [31:0] last_wd;
    exp_t        mon_e;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s           = idle();
        s.rst_n     = ($urandom_range(0, 59) != 0);
        s.alu_valid = ($urandom_range(0, 2) != 0);
        s.alu_rd    = 5'($urandom_range(0, 31));
        s.alu_wd    = $urandom;
        s.lsu_valid = ($urandom_range(0, 3) != 0);
        s.lsu_rd    = 5'($urandom_range(0, 7));
        s.lsu_wd    = $urandom;
        s.ld_issue  = ($urandom_range(0, 2) == 0);
        s.ld_rd     = 5'($urandom_range(0, 7));
        s.q_rs1     = 5'($urandom_range(0, 7));
        s.q_rs2     = 5'($urandom_range(0, 7));
        return s;
    endfunction

    // One clock cycle: check registered conflict, drive inputs, check combinational outputs,
    // advance the model and queue any write expected after the coming edge.
    task automatic applyStimulus(input stim_t s);
        bit      lsu_g;
        bit      alu_g;
        bit      was_nonempty;
        bit      exp_ar;
        bit      nf;
        wb_req_t h;
        if (sbc_known) checkOutput("sb_conflict", 32'(bus.sb_conflict), 32'(exp_sbc));
        rst           = s.rst_n;
        bus.alu_valid = s.alu_valid;
        bus.alu_rd    = s.alu_rd;
        bus.alu_wd    = s.alu_wd;
        bus.lsu_valid = s.lsu_valid;
        bus.lsu_rd    = s.lsu_rd;
        bus.lsu_wd    = s.lsu_wd;
        bus.ld_issue  = s.ld_issue;
        bus.ld_rd     = s.ld_rd;
        bus.q_rs1     = s.q_rs1;
        bus.q_rs2     = s.q_rs2;
        #1;
        if (model_valid) begin
            checkOutput("busy1", 32'(bus.busy1), 32'(mpend[s.q_rs1]));
            checkOutput("busy2", 32'(bus.busy2), 32'(mpend[s.q_rs2]));
        end
        if (!s.rst_n) begin
            checkOutput("alu_ready_in_reset", 32'(bus.alu_ready), 32'd0);
            checkOutput("lsu_ready_in_reset", 32'(bus.lsu_ready), 32'd0);
            mq.delete();
            mforce      = 1'b0;
            mstarve     = 0;
            mpend       = '0;
            exp_sbc     = 1'b0;
            sbc_known   = 1'b1;
            model_valid = 1'b1;
        end else begin
            exp_ar = (mq.size() < DEPTH);
            checkOutput("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
            checkOutput("lsu_ready", 32'(bus.lsu_ready), 32'(!mforce));
            was_nonempty = (mq.size() > 0);
            lsu_g = !mforce && s.lsu_valid;
            alu_g = !lsu_g && was_nonempty;
            if (lsu_g && s.lsu_rd != 0) expq.push_back('{edge_cnt + 1, s.lsu_rd, s.lsu_wd});
            if (alu_g) begin
                h = mq.pop_front();
                if (h.rd != 0) expq.push_back('{edge_cnt + 1, h.rd, h.wd});
            end
            nf = 1'b0;
            if (alu_g || !was_nonempty) begin
                mstarve = 0;
            end else if (lsu_g) begin
                mstarve++;
                if (mstarve == LIM) begin
                    nf      = 1'b1;
                    mstarve = 0;
                end
            end
            mforce = nf;
            if (s.alu_valid && exp_ar) mq.push_back('{rd: s.alu_rd, wd: s.alu_wd});
            exp_sbc = s.ld_issue && (s.ld_rd != 0) && mpend[s.ld_rd]
                      && !(lsu_g && s.lsu_rd == s.ld_rd);
            if (lsu_g) mpend[s.lsu_rd] = 1'b0;
            if (s.ld_issue && s.ld_rd != 0) mpend[s.ld_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen <= rst;
    end

    // Monitor: every write the DUT presents must be the oldest expected one, on its edge.
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            if (!rst_seen) begin
                checkOutput("RFWr_reset", 32'(bus.RFWr), 32'd0);
                checkOutput("A3_reset", 32'(bus.A3), 32'd0);
                checkOutput("WD_reset", bus.WD, 32'd0);
                last_a3 = '0;
                last_wd = '0;
            end else begin
                while (expq.size() > 0 && expq[0].tag < edge_cnt) begin
                    mon_e = expq.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missed_write: rd %0d data %0h due edge %0d never seen", mon_e.rd, mon_e.wd, mon_e.tag);
                end
                if (bus.RFWr === 1'b1) begin
                    if (expq.size() > 0 && expq[0].tag == edge_cnt) begin
                        mon_e = expq.pop_front();
                        checkOutput("A3", 32'(bus.A3), 32'(mon_e.rd));
                        checkOutput("WD", bus.WD, mon_e.wd);
                        last_a3 = mon_e.rd;
                        last_wd = mon_e.wd;
                    end else begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write: RFWr=1 A3=%0d WD=%0h at edge %0d, expected no write", bus.A3, bus.WD, edge_cnt);
                    end
                end else begin
                    if (expq.size() > 0 && expq[0].tag == edge_cnt) begin
                        mon_e = expq.pop_front();
                        checks++;
                        errors++;
                        $display("[TB] FAIL missing_write: RFWr=%b at edge %0d, expected rd %0d data %0h", bus.RFWr, edge_cnt, mon_e.rd, mon_e.wd);
                    end
                    checkOutput("A3_hold", 32'(bus.A3), 32'(last_a3));
                    checkOutput("WD_hold", bus.WD, last_wd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_wd    = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_wd    = '0;
        bus.ld_issue  = 1'b0;
        bus.ld_rd     = '0;
        bus.q_rs1     = '0;
        bus.q_rs2     = '0;
        @(posedge clk);
        #1;

        s = idle();
        s.rst_n = 1'b0;
        repeat (3) applyStimulus(s);

        // Lone ALU write: appears two edges after acceptance.
        s = idle();
        s.alu_valid = 1'b1; s.alu_rd = 5; s.alu_wd = 32'hDEADBEEF;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // LSU and buffered ALU head compete in the same cycle.
        s = idle();
        s.alu_valid = 1'b1; s.alu_rd = 4; s.alu_wd = 32'h22;
        applyStimulus(s);
        s = idle();
        s.lsu_valid = 1'b1; s.lsu_rd = 3; s.lsu_wd = 32'h11;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // Starvation: LSU saturating while one ALU entry waits.
        s = idle();
        s.alu_valid = 1'b1; s.alu_rd = 10; s.alu_wd = 32'hA5A5_0010;
        s.lsu_valid = 1'b1; s.lsu_rd = 11; s.lsu_wd = 32'h0000_1100;
        applyStimulus(s);
        s.alu_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s.lsu_rd = 5'(12 + i);
            s.lsu_wd = $urandom;
            applyStimulus(s);
        end
        repeat (3) applyStimulus(idle());

        // Full buffer: LSU saturating and ALU pushing every cycle.
        s = idle();
        s.lsu_valid = 1'b1;
        s.alu_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            s.alu_rd = 5'(16 + (i % 8));
            s.alu_wd = $urandom;
            s.lsu_rd = 5'(24 + (i % 8));
            s.lsu_wd = $urandom;
            applyStimulus(s);
        end
        repeat (6) applyStimulus(idle());

        // Scoreboard: set, clear, double issue, set-wins, and x0.
        s = idle(); s.ld_issue = 1'b1; s.ld_rd = 7; s.q_rs1 = 7;
        applyStimulus(s);
        s = idle(); s.q_rs1 = 7;
        applyStimulus(s);
        s = idle(); s.q_rs1 = 7; s.lsu_valid = 1'b1; s.lsu_rd = 7; s.lsu_wd = 32'h7777;
        applyStimulus(s);
        s = idle(); s.q_rs1 = 7;
        applyStimulus(s);
        s = idle(); s.ld_issue = 1'b1; s.ld_rd = 7; s.q_rs1 = 7;
        applyStimulus(s);
        applyStimulus(s);
        s = idle(); s.q_rs1 = 7;
        applyStimulus(s);
        s = idle(); s.ld_issue = 1'b1; s.ld_rd = 7; s.q_rs2 = 7;
        s.lsu_valid = 1'b1; s.lsu_rd = 7; s.lsu_wd = 32'h7070;
        applyStimulus(s);
        s = idle(); s.q_rs2 = 7; s.lsu_valid = 1'b1; s.lsu_rd = 7; s.lsu_wd = 32'h0707;
        applyStimulus(s);
        s = idle(); s.ld_issue = 1'b1; s.ld_rd = 0; s.q_rs1 = 0; s.q_rs2 = 0;
        applyStimulus(s);
        s = idle(); s.q_rs1 = 0; s.q_rs2 = 7;
        applyStimulus(s);

        // Reset while ALU data is buffered and a load is pending.
        s = idle();
        s.ld_issue = 1'b1; s.ld_rd = 9;
        s.lsu_valid = 1'b1; s.lsu_rd = 20; s.lsu_wd = 32'h2020;
        s.alu_valid = 1'b1; s.alu_rd = 21; s.alu_wd = 32'h2121;
        applyStimulus(s);
        s.ld_issue = 1'b0; s.lsu_rd = 22; s.alu_rd = 23; s.alu_wd = 32'h2323;
        applyStimulus(s);
        s.rst_n = 1'b0; s.q_rs1 = 9;
        applyStimulus(s);
        applyStimulus(s);
        s = idle(); s.q_rs1 = 9;
        repeat (4) applyStimulus(s);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(randStim());
        end

        repeat (8) applyStimulus(idle());
        checkOutput("expected_queue_drained", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
